// File: rtl/node_local_port.sv
// Router-side local port: credit-tracked flit injection toward a node and a B-deep RX FIFO returning credits.
// Optional statistics counters are built only when NODE_LOCAL_PORT_STAT_EN is defined.
module node_local_port #(
  parameter int B    = 4,
  parameter int FW   = 59,
  parameter int CNTW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inj_vld,
  input  logic [FW-1:0] inj_flit,
  output logic          inj_rdy,
  output logic          ej_vld,
  output logic [FW-1:0] ej_flit,
  input  logic          ej_rdy,
  output logic          node_flit_in_wr,
  output logic [FW-1:0] node_flit_in,
  input  logic          node_credit_out,
  input  logic          node_flit_out_wr,
  input  logic [FW-1:0] node_flit_out,
  output logic          node_credit_in,
  output logic          err_credit_ovf,
  output logic          err_rx_ovf,
  output logic [15:0]   tx_cnt,
  output logic [15:0]   rx_cnt
);

  localparam int PW = (B > 1) ? $clog2(B) : 1;

  logic [CNTW-1:0] crd_r, crd_nxt_s;
  logic            covf_set_s;
  logic            send_s, pop_s, push_s, full_s, empty_s;
  logic [PW-1:0]   wptr_r, rptr_r;
  logic [CNTW-1:0] count_r;
  logic [FW-1:0]   mem_r [B];
  logic            flit_in_wr_r, credit_in_r, covf_r, rovf_r;
  logic [FW-1:0]   flit_in_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(B - 1)) return {PW{1'b0}};
    else                 return p + PW'(1);
  endfunction

  assign inj_rdy  = (crd_r != {CNTW{1'b0}});
  assign send_s   = inj_vld & inj_rdy;
  assign full_s   = (count_r == CNTW'(B));
  assign empty_s  = (count_r == {CNTW{1'b0}});
  assign ej_vld   = ~empty_s;
  assign ej_flit  = mem_r[rptr_r];
  assign pop_s    = ej_vld & ej_rdy;
  assign push_s   = node_flit_out_wr & (~full_s | pop_s);

  assign node_flit_in_wr = flit_in_wr_r;
  assign node_flit_in    = flit_in_r;
  assign node_credit_in  = credit_in_r;
  assign err_credit_ovf  = covf_r;
  assign err_rx_ovf      = rovf_r;

  // Credit counter next value; a credit at full credit is discarded and flagged.
  always_comb begin
    crd_nxt_s  = crd_r;
    covf_set_s = 1'b0;
    if (send_s && !node_credit_out) begin
      crd_nxt_s = crd_r - CNTW'(1);
    end else if (!send_s && node_credit_out) begin
      if (crd_r == CNTW'(B)) covf_set_s = 1'b1;
      else                   crd_nxt_s  = crd_r + CNTW'(1);
    end else begin
      crd_nxt_s = crd_r;
    end
  end

  // TX registers: credit count, flit toward the node and its strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crd_r        <= CNTW'(B);
      flit_in_wr_r <= 1'b0;
      flit_in_r    <= {FW{1'b0}};
      covf_r       <= 1'b0;
    end else begin
      crd_r        <= crd_nxt_s;
      flit_in_wr_r <= send_s;
      if (send_s) flit_in_r <= inj_flit;
      if (covf_set_s) covf_r <= 1'b1;
    end
  end

  // RX FIFO storage, pointers, occupancy and the credit returned per pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < B; i++) mem_r[i] <= {FW{1'b0}};
      wptr_r      <= {PW{1'b0}};
      rptr_r      <= {PW{1'b0}};
      count_r     <= {CNTW{1'b0}};
      credit_in_r <= 1'b0;
      rovf_r      <= 1'b0;
    end else begin
      credit_in_r <= pop_s;
      if (push_s) begin
        mem_r[wptr_r] <= node_flit_out;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop_s) rptr_r <= ptr_inc(rptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
      if (node_flit_out_wr && full_s && !pop_s) rovf_r <= 1'b1;
    end
  end

`ifdef NODE_LOCAL_PORT_STAT_EN
  logic [15:0] tx_cnt_r, rx_cnt_r;

  // Wrapping flit statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt_r <= 16'd0;
      rx_cnt_r <= 16'd0;
    end else begin
      if (send_s) tx_cnt_r <= tx_cnt_r + 16'd1;
      if (push_s) rx_cnt_r <= rx_cnt_r + 16'd1;
    end
  end

  assign tx_cnt = tx_cnt_r;
  assign rx_cnt = rx_cnt_r;
`else
  assign tx_cnt = 16'd0;
  assign rx_cnt = 16'd0;
`endif

endmodule

// File: doc/node_local_port.md
# node_local_port

Router-side local port that terminates the node's credit-based flit link. It injects flits into a node and tracks the credits the node returns. It also buffers the node's outgoing flits and returns one credit per flit the router consumes. The block sits between a mesh router's local input/output channels and one `node` instance, so it is the peer of the node's `spk_in`/`spk_out` flow control.

## Interface
Parameters:
- `B`, 4: node input buffer depth; also the depth of this block's RX FIFO (credits granted to the node).
- `FW`, 59: flit width.
- `CNTW`, 3: credit counter width; must satisfy 2^CNTW > B.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `inj_vld`  in  1  router has a flit for the node.
- `inj_flit`  in  FW  flit to inject.
- `inj_rdy`  out  1  flit accepted this cycle when `inj_vld & inj_rdy`.
- `ej_vld`  out  1  RX FIFO head valid.
- `ej_flit`  out  FW  RX FIFO head flit.
- `ej_rdy`  in  1  router pops head when `ej_vld & ej_rdy`.
- `node_flit_in_wr`  out  1  write strobe to the node's `flit_in_wr`.
- `node_flit_in`  out  FW  flit to the node's `flit_in`.
- `node_credit_out`  in  1  credit pulse from the node; one pulse = one freed slot.
- `node_flit_out_wr`  in  1  flit strobe from the node.
- `node_flit_out`  in  FW  flit from the node.
- `node_credit_in`  out  1  credit pulse to the node.
- `err_credit_ovf`  out  1  sticky: credit received while the counter was already at B.
- `err_rx_ovf`  out  1  sticky: node wrote into a full RX FIFO; the flit is dropped.
- `tx_cnt`  out  16  flits injected (statistics).
- `rx_cnt`  out  16  flits received from the node (statistics).

## Operation
TX path:
- Credit counter `crd` resets to B.
- `inj_rdy = (crd != 0)`. This is combinational from the register only, with no dependency on `inj_vld`.
- On a send (`inj_vld & inj_rdy`), `inj_flit` is registered into `node_flit_in` and `node_flit_in_wr` goes high for exactly one cycle.
- With no send, `node_flit_in_wr` is 0 and `node_flit_in` holds its last value.
- Counter update: `crd_next = crd - send + node_credit_out`.
  - A send and a credit in the same cycle leave `crd` unchanged.
  - A credit arriving while `crd == B` with no send is ignored: `crd` stays B and `err_credit_ovf` is set.

RX path:
- The FIFO has B entries with read/write pointers of width clog2(B) and a count of width CNTW; pointers wrap modulo B.
- Push condition: `node_flit_out_wr & (!full | pop)`. A push while full is accepted only if a pop occurs in the same cycle.
- `node_flit_out_wr` while full with no pop: the flit is dropped, `err_rx_ovf` is set, and the pointers are unchanged.
- `ej_vld = !empty`. `ej_flit` is the head entry, read combinationally from the FIFO array.
- A pop (`ej_vld & ej_rdy`) causes `node_credit_in` to pulse high for one cycle, in the cycle after the pop.
- Simultaneous push and pop when empty: the pop is not possible because `ej_vld` is 0; the push is accepted.

Error flags:
- Both flags clear only on reset.

## Timing
- Reset (`rst_n` low at a clock edge):
  - `crd = B`; FIFO empty; pointers 0.
  - `inj_rdy = 1`, `ej_vld = 0`, `ej_flit = 0`.
  - `node_flit_in_wr = 0`, `node_flit_in = 0`, `node_credit_in = 0`.
  - Both error flags 0; `tx_cnt = rx_cnt = 0`.
- Reset mid-operation discards all buffered flits and outstanding credits. Node and port are reset together, so credit state is consistent.
- Latencies:
  - Inject to node: 1 cycle (accept at edge N, `node_flit_in_wr` high in cycle N+1).
  - Node to eject: 1 cycle (written at edge N, `ej_vld` high after edge N).
  - Pop to credit: 1 cycle.
- Throughput: one flit per cycle per direction while credits or FIFO space are available.
- The TX path stalls after B sends without returned credits.

## Configuration
- `NODE_LOCAL_PORT_STAT_EN` defined:
  - `tx_cnt` increments on each send.
  - `rx_cnt` increments on each accepted push.
  - Both are 16-bit and wrap from 0xFFFF to 0.
- Not defined: `tx_cnt` and `rx_cnt` are tied to 0 and no counter registers are built. All other behaviour is identical.

## Test plan
- Reset then hold `inj_vld = 1` for 6 cycles with no credits returned, B = 4: exactly 4 flits reach the node on consecutive cycles; `inj_rdy = 0` from the 5th cycle; `crd = 0`.
- From `crd = 0`, pulse `node_credit_out` once: `inj_rdy` rises the next cycle and exactly one more flit is sent. Then pulse a credit in the same cycle as a send: `crd` is unchanged.
- With `crd = 4`, pulse `node_credit_out`: `crd` stays 4 and `err_credit_ovf = 1` sticky until reset.
- Node writes flits 0xA, 0xB, 0xC with `ej_rdy = 0`, then `ej_rdy = 1`: the router sees A, B, C in order, and `node_credit_in` pulses 3 times, each one cycle after its pop.
- Fill the FIFO with 4 flits, then write a 5th with `ej_rdy = 0`: the flit is dropped and `err_rx_ovf = 1`. Repeat while full with `ej_rdy = 1`: the push is accepted, occupancy stays 4, no error.
- With `NODE_LOCAL_PORT_STAT_EN`, after 10 sends and 7 receives: `tx_cnt = 10`, `rx_cnt = 7`. Without the macro, both read 0.
